hazard_ctrl_n: RTL and testbench

- Parametrised successor to the pipeline redirection/hazard unit.
- Sits beside the decode stage. Compares decoded source registers against destination registers of NSTG downstream stages.
- Produces per-operand forwarding selects, load-use stall control (multi-cycle, counter-driven) and redirect flush control (multi-cycle).
- Exposes saturating stall/flush event counters for performance debug.

---
 rtl/hazard_ctrl_n.sv | 208 ++++++++++++++++++++
 tb/tb_hazard_ctrl_n.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_n.sv
// hazard_ctrl_n
//   Decode-side hazard unit. It compares the decoded source registers against
//   the destinations of NSTG downstream stages and produces:
//     - forwarding selects per operand (nearest writing stage wins),
//     - load-use stall control, which can span several cycles,
//     - redirect flush control, which spans FLUSH_LEN cycles,
//     - saturating stall and flush event counters.
//
// Ports
//   in_CLK, in_RSTN    clock (rising edge) and asynchronous active-low reset
//   in_EN              global enable; low freezes every state element
//   in_ID_VALID        decode holds a real instruction
//   in_RS/in_RT        decode source registers; in_RS_USE/in_RT_USE mark reads
//   in_DST             stage k destination at [k*RAW-1 -: RAW], k = 1..NSTG
//   in_WE, in_LOAD     per-stage register-write and is-load flags
//   in_REDIRECT        jump or taken branch resolved this cycle
//   in_CNT_CLR         synchronous clear of both event counters
//   out_FWD_RS/RT      0 = register file, k = forward from stage k
//   out_PEN, out_FDEN  PC and IF/ID enables
//   out_DECLR          bubble into ID/EX
//   out_FDCLR          clear IF/ID
//   out_BUSY           stall or flush FSM not idle
//   out_STALL_CNT      stall cycles seen
//   out_FLUSH_CNT      flush cycles seen
module hazard_ctrl_n #(
  parameter int RAW       = 5,
  parameter int NSTG      = 3,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_LEN = 1,
  parameter int CNT_W     = 16,
  localparam int SELW     = $clog2(NSTG + 1)
) (
  input  logic                  in_CLK,
  input  logic                  in_RSTN,
  input  logic                  in_EN,
  input  logic                  in_ID_VALID,
  input  logic [RAW-1:0]        in_RS,
  input  logic [RAW-1:0]        in_RT,
  input  logic                  in_RS_USE,
  input  logic                  in_RT_USE,
  input  logic [NSTG*RAW-1:0]   in_DST,
  input  logic [NSTG-1:0]       in_WE,
  input  logic [NSTG-1:0]       in_LOAD,
  input  logic                  in_REDIRECT,
  input  logic                  in_CNT_CLR,
  output logic [SELW-1:0]       out_FWD_RS,
  output logic [SELW-1:0]       out_FWD_RT,
  output logic                  out_PEN,
  output logic                  out_FDEN,
  output logic                  out_DECLR,
  output logic                  out_FDCLR,
  output logic                  out_BUSY,
  output logic [CNT_W-1:0]      out_STALL_CNT,
  output logic [CNT_W-1:0]      out_FLUSH_CNT
);

  // Stall length never exceeds LOAD_LAT <= NSTG-1, so SELW bits suffice.
  localparam int SCW = SELW;
  localparam int FCW = $clog2(FLUSH_LEN + 1);

  typedef enum logic { S_IDLE, S_STALL } stall_st_e;
  typedef enum logic { F_IDLE, F_FLUSH } flush_st_e;

  stall_st_e          sst_q, sst_d;
  flush_st_e          fst_q, fst_d;
  logic [SCW-1:0]     scnt_q, scnt_d;
  logic [FCW-1:0]     fcnt_q, fcnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;

  logic [SELW-1:0]    sel_rs, sel_rt;
  logic [SCW-1:0]     need_rs, need_rt, need_max;
  logic               hz, stall_act, flush_act;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Cycles still needed before the producer in stage 'sel' can forward,
  // zero when the producer is not a load or is already far enough along.
  function automatic logic [SCW-1:0] load_need(input logic [SELW-1:0] sel,
                                               input logic [NSTG-1:0] ld);
    logic [SCW-1:0] n;
    n = '0;
    for (int k = 1; k <= NSTG; k++) begin
      if (sel == SELW'(k) && k <= LOAD_LAT && ld[k-1]) n = SCW'(LOAD_LAT + 1 - k);
    end
    return n;
  endfunction

  // Scan from oldest to nearest so the nearest matching producer wins.
  always_comb begin
    sel_rs = '0;
    sel_rt = '0;
    for (int k = NSTG; k >= 1; k--) begin
      if (in_WE[k-1] && in_DST[k*RAW-1 -: RAW] == in_RS && in_RS != '0) sel_rs = SELW'(k);
      if (in_WE[k-1] && in_DST[k*RAW-1 -: RAW] == in_RT && in_RT != '0) sel_rt = SELW'(k);
    end
    if (!(in_RS_USE && in_ID_VALID)) sel_rs = '0;
    if (!(in_RT_USE && in_ID_VALID)) sel_rt = '0;
  end

  assign out_FWD_RS = sel_rs;
  assign out_FWD_RT = sel_rt;

  always_comb begin
    need_rs  = load_need(sel_rs, in_LOAD);
    need_rt  = load_need(sel_rt, in_LOAD);
    need_max = (need_rs > need_rt) ? need_rs : need_rt;
    hz       = (need_max != '0);
  end

  // A flush (fresh redirect or ongoing) always overrides stalling so the
  // redirect target is fetched; in STALL the decode inputs are ignored.
  always_comb begin
    flush_act = in_EN && (in_REDIRECT || fst_q == F_FLUSH);
    stall_act = in_EN && !flush_act && (sst_q == S_STALL || hz);
  end

  always_comb begin
    sst_d  = sst_q;
    scnt_d = scnt_q;
    if (in_EN) begin
      if (flush_act) begin
        sst_d  = S_IDLE;
        scnt_d = '0;
      end else begin
        case (sst_q)
          S_IDLE: begin
            if (hz && need_max > SCW'(1)) begin
              sst_d  = S_STALL;
              scnt_d = need_max - SCW'(1);
            end
          end
          S_STALL: begin
            if (scnt_q <= SCW'(1)) begin
              sst_d  = S_IDLE;
              scnt_d = '0;
            end else begin
              scnt_d = scnt_q - SCW'(1);
            end
          end
          default: begin
            sst_d  = S_IDLE;
            scnt_d = '0;
          end
        endcase
      end
    end
  end

  // A redirect seen while already flushing restarts the count.
  always_comb begin
    fst_d  = fst_q;
    fcnt_d = fcnt_q;
    if (in_EN) begin
      if (in_REDIRECT) begin
        if (FLUSH_LEN > 1) begin
          fst_d  = F_FLUSH;
          fcnt_d = FCW'(FLUSH_LEN - 1);
        end else begin
          fst_d  = F_IDLE;
          fcnt_d = '0;
        end
      end else if (fst_q == F_FLUSH) begin
        if (fcnt_q <= FCW'(1)) begin
          fst_d  = F_IDLE;
          fcnt_d = '0;
        end else begin
          fcnt_d = fcnt_q - FCW'(1);
        end
      end
    end
  end

  always_ff @(posedge in_CLK or negedge in_RSTN) begin
    if (!in_RSTN) begin
      sst_q       <= S_IDLE;
      fst_q       <= F_IDLE;
      scnt_q      <= '0;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      sst_q  <= sst_d;
      fst_q  <= fst_d;
      scnt_q <= scnt_d;
      fcnt_q <= fcnt_d;
      if (in_EN) begin
        if (in_CNT_CLR) begin
          stall_cnt_q <= '0;
          flush_cnt_q <= '0;
        end else begin
          if (stall_act) stall_cnt_q <= sat_inc(stall_cnt_q);
          if (flush_act) flush_cnt_q <= sat_inc(flush_cnt_q);
        end
      end
    end
  end

  assign out_PEN       = in_EN && !stall_act;
  assign out_FDEN      = in_EN && !stall_act;
  assign out_DECLR     = stall_act || flush_act;
  assign out_FDCLR     = flush_act;
  assign out_BUSY      = (sst_q != S_IDLE) || (fst_q != F_IDLE);
  assign out_STALL_CNT = stall_cnt_q;
  assign out_FLUSH_CNT = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_n.sv
module tb_hazard_ctrl_n;

  logic        clk = 1'b0;
  logic        rstn, en, idv, rsu, rtu, redir, clr;
  logic [4:0]  rs, rt;
  logic [14:0] dst;
  logic [2:0]  we, ld;
  logic [1:0]  fwd_rs, fwd_rt;
  logic        pen, fden, declr, fdclr, busy;
  logic [3:0]  scnt, fcnt;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  hazard_ctrl_n #(.RAW(5), .NSTG(3), .LOAD_LAT(2), .FLUSH_LEN(3), .CNT_W(4)) dut (
    .in_CLK(clk), .in_RSTN(rstn), .in_EN(en), .in_ID_VALID(idv),
    .in_RS(rs), .in_RT(rt), .in_RS_USE(rsu), .in_RT_USE(rtu),
    .in_DST(dst), .in_WE(we), .in_LOAD(ld), .in_REDIRECT(redir),
    .in_CNT_CLR(clr), .out_FWD_RS(fwd_rs), .out_FWD_RT(fwd_rt),
    .out_PEN(pen), .out_FDEN(fden), .out_DECLR(declr), .out_FDCLR(fdclr),
    .out_BUSY(busy), .out_STALL_CNT(scnt), .out_FLUSH_CNT(fcnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    idv = 1'b0; rs = '0; rt = '0; rsu = 1'b0; rtu = 1'b0;
    dst = '0; we = '0; ld = '0; redir = 1'b0; clr = 1'b0;
  endtask

  task automatic set_stage(input int k, input logic [4:0] r, input logic w, input logic l);
    dst[k*5-1 -: 5] = r;
    we[k-1] = w;
    ld[k-1] = l;
  endtask

  task automatic clear_counters();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    en = 1'b1;
    rstn = 1'b0;
    #3;
    ncmp++; if (pen !== 1'b1) begin $display("FAIL reset_pen got %0d want 1", pen); nfail++; end
    ncmp++; if (fden !== 1'b1) begin $display("FAIL reset_fden got %0d want 1", fden); nfail++; end
    ncmp++; if (declr !== 1'b0) begin $display("FAIL reset_declr got %0d want 0", declr); nfail++; end
    ncmp++; if (fdclr !== 1'b0) begin $display("FAIL reset_fdclr got %0d want 0", fdclr); nfail++; end
    ncmp++; if (busy !== 1'b0) begin $display("FAIL reset_busy got %0d want 0", busy); nfail++; end
    ncmp++; if (scnt !== 4'd0) begin $display("FAIL reset_stall_cnt got %0d want 0", scnt); nfail++; end
    ncmp++; if (fcnt !== 4'd0) begin $display("FAIL reset_flush_cnt got %0d want 0", fcnt); nfail++; end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_forward();
    clear_inputs();
    idv = 1'b1; rs = 5'd8; rsu = 1'b1; rt = 5'd8; rtu = 1'b0;
    set_stage(1, 5'd8, 1'b1, 1'b0);
    set_stage(2, 5'd8, 1'b1, 1'b0);
    #1;
    ncmp++; if (fwd_rs !== 2'd1) begin $display("FAIL fwd_nearest got %0d want 1", fwd_rs); nfail++; end
    ncmp++; if (fwd_rt !== 2'd0) begin $display("FAIL fwd_rt_unused got %0d want 0", fwd_rt); nfail++; end
    ncmp++; if (pen !== 1'b1) begin $display("FAIL fwd_no_stall_pen got %0d want 1", pen); nfail++; end
    we[0] = 1'b0;
    #1;
    ncmp++; if (fwd_rs !== 2'd2) begin $display("FAIL fwd_stage2 got %0d want 2", fwd_rs); nfail++; end
    idv = 1'b0;
    #1;
    ncmp++; if (fwd_rs !== 2'd0) begin $display("FAIL fwd_invalid got %0d want 0", fwd_rs); nfail++; end
    idv = 1'b1; rs = 5'd0;
    set_stage(1, 5'd0, 1'b1, 1'b0);
    #1;
    ncmp++; if (fwd_rs !== 2'd0) begin $display("FAIL fwd_r0 got %0d want 0", fwd_rs); nfail++; end
    clear_inputs();
    tick();
  endtask

  task automatic test_load_use();
    clear_counters();
    idv = 1'b1; rt = 5'd9; rtu = 1'b1;
    set_stage(1, 5'd9, 1'b1, 1'b1);
    set_stage(3, 5'd9, 1'b1, 1'b0);
    #1;
    ncmp++; if (fwd_rt !== 2'd1) begin $display("FAIL lu_fwd_rt got %0d want 1", fwd_rt); nfail++; end
    ncmp++; if (pen !== 1'b0) begin $display("FAIL lu_c1_pen got %0d want 0", pen); nfail++; end
    ncmp++; if (fden !== 1'b0) begin $display("FAIL lu_c1_fden got %0d want 0", fden); nfail++; end
    ncmp++; if (declr !== 1'b1) begin $display("FAIL lu_c1_declr got %0d want 1", declr); nfail++; end
    ncmp++; if (busy !== 1'b0) begin $display("FAIL lu_c1_busy got %0d want 0", busy); nfail++; end
    tick();
    set_stage(1, 5'd0, 1'b0, 1'b0);
    set_stage(2, 5'd9, 1'b1, 1'b1);
    set_stage(3, 5'd0, 1'b0, 1'b0);
    #1;
    ncmp++; if (pen !== 1'b0) begin $display("FAIL lu_c2_pen got %0d want 0", pen); nfail++; end
    ncmp++; if (declr !== 1'b1) begin $display("FAIL lu_c2_declr got %0d want 1", declr); nfail++; end
    ncmp++; if (busy !== 1'b1) begin $display("FAIL lu_c2_busy got %0d want 1", busy); nfail++; end
    tick();
    set_stage(2, 5'd0, 1'b0, 1'b0);
    set_stage(3, 5'd9, 1'b1, 1'b1);
    #1;
    ncmp++; if (fwd_rt !== 2'd3) begin $display("FAIL lu_c3_fwd_rt got %0d want 3", fwd_rt); nfail++; end
    ncmp++; if (pen !== 1'b1) begin $display("FAIL lu_c3_pen got %0d want 1", pen); nfail++; end
    ncmp++; if (declr !== 1'b0) begin $display("FAIL lu_c3_declr got %0d want 0", declr); nfail++; end
    ncmp++; if (busy !== 1'b0) begin $display("FAIL lu_c3_busy got %0d want 0", busy); nfail++; end
    ncmp++; if (scnt !== 4'd2) begin $display("FAIL lu_stall_cnt got %0d want 2", scnt); nfail++; end
    // Load in stage 2 needs exactly one bubble and never leaves IDLE.
    set_stage(3, 5'd0, 1'b0, 1'b0);
    set_stage(2, 5'd9, 1'b1, 1'b1);
    #1;
    ncmp++; if (pen !== 1'b0) begin $display("FAIL lu1_pen got %0d want 0", pen); nfail++; end
    tick();
    clear_inputs();
    #1;
    ncmp++; if (busy !== 1'b0) begin $display("FAIL lu1_busy got %0d want 0", busy); nfail++; end
    ncmp++; if (pen !== 1'b1) begin $display("FAIL lu1_after_pen got %0d want 1", pen); nfail++; end
    ncmp++; if (scnt !== 4'd3) begin $display("FAIL lu1_stall_cnt got %0d want 3", scnt); nfail++; end
    tick();
  endtask

  task automatic test_redirect_in_stall();
    clear_inputs();
    idv = 1'b1; rs = 5'd9; rsu = 1'b1;
    set_stage(1, 5'd9, 1'b1, 1'b1);
    #1;
    ncmp++; if (pen !== 1'b0) begin $display("FAIL rs_c1_pen got %0d want 0", pen); nfail++; end
    tick();
    redir = 1'b1;
    #1;
    ncmp++; if (fdclr !== 1'b1) begin $display("FAIL rs_c2_fdclr got %0d want 1", fdclr); nfail++; end
    ncmp++; if (pen !== 1'b1) begin $display("FAIL rs_c2_pen got %0d want 1", pen); nfail++; end
    ncmp++; if (fden !== 1'b1) begin $display("FAIL rs_c2_fden got %0d want 1", fden); nfail++; end
    ncmp++; if (declr !== 1'b1) begin $display("FAIL rs_c2_declr got %0d want 1", declr); nfail++; end
    tick();
    clear_inputs();
    #1;
    ncmp++; if (fdclr !== 1'b1) begin $display("FAIL rs_c3_fdclr got %0d want 1", fdclr); nfail++; end
    ncmp++; if (busy !== 1'b1) begin $display("FAIL rs_c3_busy got %0d want 1", busy); nfail++; end
    tick();
    ncmp++; if (fdclr !== 1'b1) begin $display("FAIL rs_c4_fdclr got %0d want 1", fdclr); nfail++; end
    tick();
    ncmp++; if (fdclr !== 1'b0) begin $display("FAIL rs_c5_fdclr got %0d want 0", fdclr); nfail++; end
    ncmp++; if (busy !== 1'b0) begin $display("FAIL rs_c5_busy got %0d want 0", busy); nfail++; end
    tick();
  endtask

  task automatic test_flush_restart();
    logic [6:0] exp_f;
    exp_f = 7'b0011111;
    clear_inputs();
    clear_counters();
    for (int t = 0; t < 7; t++) begin
      redir = (t == 0 || t == 2);
      #1;
      ncmp++;
      if (fdclr !== exp_f[t]) begin
        $display("FAIL flush_t%0d got %0d want %0d", t, fdclr, exp_f[t]); nfail++;
      end
      tick();
    end
    redir = 1'b0;
    ncmp++; if (fcnt !== 4'd5) begin $display("FAIL flush_cnt got %0d want 5", fcnt); nfail++; end
  endtask

  task automatic test_enable();
    clear_inputs();
    clear_counters();
    idv = 1'b1; rt = 5'd9; rtu = 1'b1;
    set_stage(1, 5'd9, 1'b1, 1'b1);
    #1;
    ncmp++; if (pen !== 1'b0) begin $display("FAIL en_c1_pen got %0d want 0", pen); nfail++; end
    tick();
    en = 1'b0;
    clear_inputs();
    idv = 1'b1; rs = 5'd9; rsu = 1'b1;
    set_stage(3, 5'd9, 1'b1, 1'b0);
    #1;
    ncmp++; if (pen !== 1'b0) begin $display("FAIL en_off_pen got %0d want 0", pen); nfail++; end
    ncmp++; if (fden !== 1'b0) begin $display("FAIL en_off_fden got %0d want 0", fden); nfail++; end
    ncmp++; if (declr !== 1'b0) begin $display("FAIL en_off_declr got %0d want 0", declr); nfail++; end
    ncmp++; if (fdclr !== 1'b0) begin $display("FAIL en_off_fdclr got %0d want 0", fdclr); nfail++; end
    ncmp++; if (fwd_rs !== 2'd3) begin $display("FAIL en_off_fwd got %0d want 3", fwd_rs); nfail++; end
    repeat (3) tick();
    ncmp++; if (busy !== 1'b1) begin $display("FAIL en_off_busy got %0d want 1", busy); nfail++; end
    ncmp++; if (scnt !== 4'd1) begin $display("FAIL en_off_cnt got %0d want 1", scnt); nfail++; end
    en = 1'b1;
    #1;
    ncmp++; if (pen !== 1'b0) begin $display("FAIL en_resume_pen got %0d want 0", pen); nfail++; end
    ncmp++; if (declr !== 1'b1) begin $display("FAIL en_resume_declr got %0d want 1", declr); nfail++; end
    tick();
    ncmp++; if (pen !== 1'b1) begin $display("FAIL en_done_pen got %0d want 1", pen); nfail++; end
    ncmp++; if (busy !== 1'b0) begin $display("FAIL en_done_busy got %0d want 0", busy); nfail++; end
    ncmp++; if (scnt !== 4'd2) begin $display("FAIL en_done_cnt got %0d want 2", scnt); nfail++; end
    clear_inputs();
    tick();
  endtask

  task automatic test_saturation();
    clear_inputs();
    clear_counters();
    idv = 1'b1; rs = 5'd9; rsu = 1'b1;
    set_stage(2, 5'd9, 1'b1, 1'b1);
    repeat (20) tick();
    ncmp++; if (scnt !== 4'd15) begin $display("FAIL sat_cnt got %0d want 15", scnt); nfail++; end
    clr = 1'b1;
    tick();
    ncmp++; if (scnt !== 4'd0) begin $display("FAIL sat_clr got %0d want 0", scnt); nfail++; end
    clear_inputs();
    tick();
  endtask

  task automatic test_async_reset();
    clear_inputs();
    redir = 1'b1;
    tick();
    redir = 1'b0;
    #1;
    ncmp++; if (fdclr !== 1'b1) begin $display("FAIL ar_pre_fdclr got %0d want 1", fdclr); nfail++; end
    rstn = 1'b0;
    #1;
    ncmp++; if (fdclr !== 1'b0) begin $display("FAIL ar_fdclr got %0d want 0", fdclr); nfail++; end
    ncmp++; if (busy !== 1'b0) begin $display("FAIL ar_busy got %0d want 0", busy); nfail++; end
    ncmp++; if (fcnt !== 4'd0) begin $display("FAIL ar_flush_cnt got %0d want 0", fcnt); nfail++; end
    #1;
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    en = 1'b1;
    rstn = 1'b1;
    clear_inputs();
    test_reset();
    test_forward();
    test_load_use();
    test_redirect_in_stall();
    test_flush_restart();
    test_enable();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
